// File: rtl/seg7_result_rx.sv
`default_nettype none
// ============================================================================
// Module   : seg7_result_rx
// Purpose  : Decodes a serialised 7-segment result frame (carry + 4 digits)
//            back into packed BCD, a binary value and an illegal-symbol flag.
// Revision : 1.0
// ============================================================================
module seg7_result_rx #(
  parameter int SEG_W = 7,
  parameter int NDIG  = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  input  logic                 in_sof,
  input  logic [SEG_W-1:0]     seg_in,
  output logic                 in_ready,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [4*NDIG-1:0]    bcd_out,
  output logic                 carry_out,
  output logic [14:0]          bin_out,
  output logic                 err,
  output logic                 resync
);

  typedef enum logic [2:0] {
    S_WAIT_SOF = 3'd0,
    S_D3       = 3'd1,
    S_D2       = 3'd2,
    S_D1       = 3'd3,
    S_D0       = 3'd4,
    S_HOLD     = 3'd5
  } state_t;

  state_t                  state_q;
  logic [14:0]             acc_q;
  logic [4*(NDIG-1)-1:0]   digits_q;
  logic                    carry_q;
  logic                    err_q;

  logic [3:0]              dig_field_d;
  logic                    dig_ill_d;
  logic                    car_val_d;
  logic                    car_ill_d;
  logic [14:0]             acc_d;

  always_comb begin
    dig_field_d = 4'hF;
    dig_ill_d   = 1'b0;
    unique case (seg_in)
      7'h7E:   dig_field_d = 4'd0;
      7'h30:   dig_field_d = 4'd1;
      7'h6D:   dig_field_d = 4'd2;
      7'h79:   dig_field_d = 4'd3;
      7'h33:   dig_field_d = 4'd4;
      7'h5B:   dig_field_d = 4'd5;
      7'h5F:   dig_field_d = 4'd6;
      7'h70:   dig_field_d = 4'd7;
      7'h7F:   dig_field_d = 4'd8;
      7'h7B:   dig_field_d = 4'd9;
      default: dig_ill_d   = 1'b1;
    endcase

    car_val_d = 1'b0;
    car_ill_d = 1'b0;
    if (seg_in == 7'h30) begin
      car_val_d = 1'b1;
    end else if (seg_in != 7'h00) begin
      car_ill_d = 1'b1;
    end

    // Carry seeds the accumulator as the leading decade, so four x10 steps
    // scale it to 10000 while the digits fill in below it.
    acc_d = (acc_q << 3) + (acc_q << 1) + {11'd0, (dig_ill_d ? 4'd0 : dig_field_d)};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_WAIT_SOF;
      acc_q     <= '0;
      digits_q  <= '0;
      carry_q   <= 1'b0;
      err_q     <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      bcd_out   <= '0;
      carry_out <= 1'b0;
      bin_out   <= '0;
      err       <= 1'b0;
      resync    <= 1'b0;
    end else begin
      resync <= 1'b0;
      if (state_q == S_HOLD) begin
        if (out_ready) begin
          state_q   <= S_WAIT_SOF;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
        end
      end else if (in_valid && in_ready) begin
        if (in_sof) begin
          // A start-of-frame always restarts, abandoning any partial frame.
          carry_q <= car_val_d;
          acc_q   <= {14'd0, car_val_d};
          err_q   <= car_ill_d;
          state_q <= S_D3;
          if (state_q != S_WAIT_SOF) begin
            resync <= 1'b1;
          end
        end else if (state_q != S_WAIT_SOF) begin
          digits_q <= {digits_q[4*(NDIG-1)-5:0], dig_field_d};
          acc_q    <= acc_d;
          err_q    <= err_q | dig_ill_d;
          unique case (state_q)
            S_D3:    state_q <= S_D2;
            S_D2:    state_q <= S_D1;
            S_D1:    state_q <= S_D0;
            default: begin
              state_q   <= S_HOLD;
              in_ready  <= 1'b0;
              out_valid <= 1'b1;
              bcd_out   <= {digits_q, dig_field_d};
              carry_out <= carry_q;
              bin_out   <= acc_d;
              err       <= err_q | dig_ill_d;
            end
          endcase
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_seg7_result_rx.sv
`default_nettype none
// Directed bench for seg7_result_rx: a frame-level reference model is compared
// every cycle, plus literal expectations for each directed frame.
module tb_seg7_result_rx;

  logic        clk = 1'b0;
  logic        rst_n, in_valid, in_sof, out_ready;
  logic [6:0]  seg_in;
  logic        in_ready, out_valid, carry_out, err, resync;
  logic [15:0] bcd_out;
  logic [14:0] bin_out;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  seg7_result_rx #(.SEG_W(7), .NDIG(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_sof(in_sof),
    .seg_in(seg_in), .in_ready(in_ready), .out_valid(out_valid),
    .out_ready(out_ready), .bcd_out(bcd_out), .carry_out(carry_out),
    .bin_out(bin_out), .err(err), .resync(resync)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: collects the symbols of a frame, decodes it as a whole.
  int          pat[10] = '{'h7E, 'h30, 'h6D, 'h79, 'h33, 'h5B, 'h5F, 'h70, 'h7F, 'h7B};
  int          wgt[4]  = '{1000, 100, 10, 1};
  int          syms[$];
  bit          m_coll, m_hold, started;
  logic        e_ready, e_valid, e_carry, e_err, e_resync;
  logic [15:0] e_bcd;
  int          e_bin;

  function automatic int dec_dig(input int s);
    for (int k = 0; k < 10; k++) if (pat[k] == s) return k;
    return -1;
  endfunction

  task automatic decode_frame();
    int d;
    e_err   = 1'b0;
    e_carry = 1'b0;
    e_bin   = 0;
    if (syms[0] == 'h30) begin
      e_carry = 1'b1;
      e_bin   = 10000;
    end else if (syms[0] != 0) begin
      e_err = 1'b1;
    end
    e_bcd = 16'h0;
    for (int k = 1; k <= 4; k++) begin
      d = dec_dig(syms[k]);
      if (d < 0) begin
        e_err = 1'b1;
        e_bcd = {e_bcd[11:0], 4'hF};
      end else begin
        e_bin += d * wgt[k-1];
        e_bcd = {e_bcd[11:0], 4'(d)};
      end
    end
  endtask

  always @(posedge clk) begin
    if (!rst_n) begin
      started = 1'b1;
      m_coll = 0; m_hold = 0; syms.delete();
      e_valid = 0; e_bcd = 0; e_carry = 0; e_bin = 0; e_err = 0; e_resync = 0;
    end else begin
      e_resync = 1'b0;
      if (m_hold) begin
        if (out_ready) begin
          m_hold  = 0;
          e_valid = 0;
        end
      end else if (in_valid) begin
        if (in_sof) begin
          if (m_coll) e_resync = 1'b1;
          syms.delete();
          syms.push_back(int'(seg_in));
          m_coll = 1;
        end else if (m_coll) begin
          syms.push_back(int'(seg_in));
          if (syms.size() == 5) begin
            decode_frame();
            m_hold  = 1;
            m_coll  = 0;
            e_valid = 1;
          end
        end
      end
    end
    e_ready = !m_hold;
  end

  always @(negedge clk) begin
    if (started) begin
      chk("m_in_ready", in_ready, e_ready);
      chk("m_out_valid", out_valid, e_valid);
      chk("m_bcd_out", bcd_out, e_bcd);
      chk("m_carry_out", carry_out, e_carry);
      chk("m_bin_out", bin_out, e_bin);
      chk("m_err", err, e_err);
      chk("m_resync", resync, e_resync);
    end
  end

  task automatic send(input logic [6:0] s, input logic sof);
    in_valid = 1'b1; in_sof = sof; seg_in = s;
    @(posedge clk); #1;
    in_valid = 1'b0; in_sof = 1'b0;
  endtask

  task automatic send_frame(input logic [6:0] c, d3, d2, d1, d0);
    send(c, 1'b1); send(d3, 1'b0); send(d2, 1'b0); send(d1, 1'b0); send(d0, 1'b0);
  endtask

  task automatic expect_frame(input string nm, input logic [15:0] bcd, input int bin,
                              input logic car, input logic er);
    chk({nm, "_valid"}, out_valid, 1'b1);
    chk({nm, "_bcd"}, bcd_out, bcd);
    chk({nm, "_bin"}, bin_out, bin);
    chk({nm, "_carry"}, carry_out, car);
    chk({nm, "_err"}, err, er);
  endtask

  task automatic idle();
    @(posedge clk); #1;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_sof = 1'b0; seg_in = 7'h0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_bcd", bcd_out, 16'h0);
    rst_n = 1'b1;
    idle();

    send_frame(7'h00, 7'h5B, 7'h5B, 7'h5B, 7'h5B);
    expect_frame("f5555", 16'h5555, 5555, 1'b0, 1'b0);
    chk("f5555_in_ready", in_ready, 1'b0);
    idle();
    chk("f5555_ready_back", in_ready, 1'b1);

    send_frame(7'h30, 7'h7E, 7'h7E, 7'h7E, 7'h7E);
    expect_frame("f10000", 16'h0000, 10000, 1'b1, 1'b0);
    idle();
    send_frame(7'h30, 7'h7B, 7'h7B, 7'h7B, 7'h7B);
    expect_frame("f19999", 16'h9999, 19999, 1'b1, 1'b0);
    idle();

    send_frame(7'h00, 7'h30, 7'h6D, 7'h12, 7'h33);
    expect_frame("fillegal", 16'h12F4, 1204, 1'b0, 1'b1);
    idle();
    send_frame(7'h00, 7'h7E, 7'h7E, 7'h7E, 7'h30);
    expect_frame("fclean", 16'h0001, 1, 1'b0, 1'b0);
    idle();
    send_frame(7'h12, 7'h30, 7'h30, 7'h30, 7'h30);
    expect_frame("fbadcarry", 16'h1111, 1111, 1'b0, 1'b1);
    idle();

    send(7'h5B, 1'b0); send(7'h5B, 1'b0);
    send_frame(7'h00, 7'h79, 7'h79, 7'h79, 7'h79);
    expect_frame("fdrop", 16'h3333, 3333, 1'b0, 1'b0);
    idle();

    send(7'h30, 1'b1); send(7'h5B, 1'b0); send(7'h00, 1'b1);
    chk("resync_pulse", resync, 1'b1);
    send(7'h79, 1'b0);
    chk("resync_clear", resync, 1'b0);
    send(7'h79, 1'b0); send(7'h79, 1'b0); send(7'h79, 1'b0);
    expect_frame("fresync", 16'h3333, 3333, 1'b0, 1'b0);
    idle();

    out_ready = 1'b0;
    send_frame(7'h00, 7'h5F, 7'h70, 7'h7F, 7'h7B);
    expect_frame("fhold", 16'h6789, 6789, 1'b0, 1'b0);
    in_valid = 1'b1; in_sof = 1'b1; seg_in = 7'h30;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("hold_in_ready", in_ready, 1'b0);
      chk("hold_valid", out_valid, 1'b1);
      chk("hold_bcd", bcd_out, 16'h6789);
    end
    out_ready = 1'b1;
    idle();
    chk("release_valid", out_valid, 1'b0);
    chk("release_ready", in_ready, 1'b1);
    chk("release_keep_bcd", bcd_out, 16'h6789);
    idle();
    in_valid = 1'b0; in_sof = 1'b0;
    send(7'h7E, 1'b0); send(7'h7E, 1'b0); send(7'h7E, 1'b0); send(7'h7E, 1'b0);
    expect_frame("fafterhold", 16'h0000, 10000, 1'b1, 1'b0);
    idle();

    send(7'h00, 1'b1); send(7'h5B, 1'b0); send(7'h5B, 1'b0);
    rst_n = 1'b0;
    idle();
    rst_n = 1'b1;
    chk("midrst_valid", out_valid, 1'b0);
    chk("midrst_bcd", bcd_out, 16'h0);
    chk("midrst_bin", bin_out, 0);
    chk("midrst_carry", carry_out, 1'b0);
    chk("midrst_ready", in_ready, 1'b1);
    send(7'h5B, 1'b0);
    send_frame(7'h00, 7'h6D, 7'h30, 7'h33, 7'h5B);
    expect_frame("fpostrst", 16'h2145, 2145, 1'b0, 1'b0);
    idle();
    idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
